rotator_arbiter_4req: RTL and testbench



---
 rtl/rotator_arbiter_4req.sv | 122 ++++++++++++
 tb/tb_rotator_arbiter_4req.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotator_arbiter_4req.sv
// Round-robin arbiter that shares one 32-bit rotator between four requesters, with a one-deep result register.
// Optional completed-operation counter enabled by defining ROT_ARB_CNT_EN.
module rotator_arbiter_4req #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic [127:0]     req_data,
    input  logic [19:0]      req_amt,
    input  logic [3:0]       req_dir,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [1:0]       res_id,
    output logic [CNT_W-1:0] op_count
);

    logic [31:0] op_data [4];
    logic [4:0]  op_amt  [4];

    logic [1:0]  ptr_reg;
    logic        res_valid_reg;
    logic [31:0] res_data_reg;
    logic [1:0]  res_id_reg;

    logic        out_free;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        accept;
    logic [31:0] sel_data;
    logic [4:0]  sel_amt;
    logic        sel_dir;
    logic [31:0] rot_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign op_data[gi] = req_data[32*gi +: 32];
            assign op_amt[gi]  = req_amt[5*gi +: 5];
        end
    endgenerate

    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign out_free = rst_n && (!res_valid_reg || res_ready);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_reg + 2'(k);
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
        if (!out_free) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    assign sel_data = op_data[grant_id];
    assign sel_amt  = op_amt[grant_id];
    assign sel_dir  = req_dir[grant_id];

    // A shift by 32 yields zero, so amt=0 passes the operand through untouched.
    always_comb begin
        rot_data = '0;
        if (sel_dir) begin
            rot_data = (sel_data >> sel_amt) | (sel_data << (6'd32 - {1'b0, sel_amt}));
        end else begin
            rot_data = (sel_data << sel_amt) | (sel_data >> (6'd32 - {1'b0, sel_amt}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
        end else begin
            if (accept) begin
                ptr_reg       <= grant_id + 2'd1;
                res_valid_reg <= 1'b1;
                res_data_reg  <= rot_data;
                res_id_reg    <= grant_id;
            end else if (res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;

`ifdef ROT_ARB_CNT_EN
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (res_valid_reg && res_ready && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign op_count = count_reg;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_rotator_arbiter_4req.sv
// Self-checking bench for rotator_arbiter_4req: scenario tasks with a result scoreboard queue.
// Define ROT_ARB_CNT_EN to build and check the counter with CNT_W=4.
module tb_rotator_arbiter_4req;

`ifdef ROT_ARB_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [127:0]     req_data;
    logic [19:0]      req_amt;
    logic [3:0]       req_dir;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [1:0]       res_id;
    logic [CNT_W-1:0] op_count;

    int          checks;
    int          failures;
    logic [1:0]  mptr;
    bit          mvalid;
    int          hs;
    logic [33:0] sbq[$];

    rotator_arbiter_4req #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rot(input logic [31:0] a, input int amt, input bit dir);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            if (dir) r[(k - amt + 32) % 32] = a[k];
            else     r[(k + amt) % 32] = a[k];
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_grant();
        int idx;
        if (!rst_n) return 4'b0000;
        if (mvalid && !res_ready) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(mptr) + k) % 4;
            if (req_valid[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    function automatic logic [CNT_W-1:0] exp_count();
`ifdef ROT_ARB_CNT_EN
        if (hs > (1 << CNT_W) - 1) return {CNT_W{1'b1}};
        return CNT_W'(hs);
`else
        return '0;
`endif
    endfunction

    // Advance one clock, updating the reference model and scoreboard from the driven stimulus.
    task automatic tick(output logic [3:0] g);
        int idx;
        g = exp_grant();
        @(posedge clk);
        if (rst_n) begin
            if (mvalid && res_ready) begin
                hs++;
                sbq.delete(0);
                mvalid = 1'b0;
            end
            if (g != 4'b0000) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (g[k]) idx = k;
                sbq.push_back({2'(idx), model_rot(req_data[32*idx +: 32], int'(req_amt[5*idx +: 5]), req_dir[idx])});
                mvalid = 1'b1;
                mptr   = 2'(idx + 1);
            end
        end
        #1;
        if (res_valid) $display("txn res_id=%0d res_data=%08h op_count=%0d", res_id, res_data, op_count);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mvalid = 1'b0;
        mptr = 2'd0;
        hs = 0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
        req_data = {4{32'hA5A5_5A5A}};
        req_amt = '0;
        req_dir = '0;
        mvalid = 1'b0;
        mptr = 2'd0;
        hs = 0;
        #12;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b want=0", res_valid); end
        checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got=%08h want=00000000", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d want=0", res_id); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%04b want=0000", req_ready); end
        checks++; if (op_count !== '0) begin failures++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
        req_valid = 4'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_single();
        logic [3:0]  g;
        int          ids[3]  = '{1, 2, 2};
        logic [4:0]  amts[3] = '{5'd1, 5'd4, 5'd0};
        bit          dirs[3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] want[3] = '{32'hC000_0000, 32'h0000_0018, 32'h8000_0001};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data[32*ids[i] +: 32] = 32'h8000_0001;
            req_amt[5*ids[i] +: 5] = amts[i];
            req_dir[ids[i]] = dirs[i];
            req_valid = 4'(1 << ids[i]);
            #1;
            checks++; if (req_ready !== 4'(1 << ids[i])) begin failures++; $display("FAIL single_ready[%0d] got=%04b want=%04b", i, req_ready, 4'(1 << ids[i])); end
            tick(g);
            req_valid = 4'h0;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%0b want=1", i, res_valid); end
            checks++; if (res_data !== want[i]) begin failures++; $display("FAIL single_data[%0d] got=%08h want=%08h", i, res_data, want[i]); end
            checks++; if (res_id !== 2'(ids[i])) begin failures++; $display("FAIL single_id[%0d] got=%0d want=%0d", i, res_id, ids[i]); end
            tick(g);
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain[%0d] got=%0b want=0", i, res_valid); end
            checks++; if (res_data !== want[i]) begin failures++; $display("FAIL single_hold[%0d] got=%08h want=%08h", i, res_data, want[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[32*i +: 32] = $urandom;
            req_amt[5*i +: 5] = 5'($urandom_range(0, 31));
            req_dir[i] = 1'($urandom_range(0, 1));
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_ready[%0d] got=%04b want=%04b", i, req_ready, 4'(1 << (i % 4))); end
            tick(g);
            checks++; if (res_valid !== 1'b1 || res_id !== 2'(i % 4)) begin failures++; $display("FAIL rr_id[%0d] got=%0b/%0d want=1/%0d", i, res_valid, res_id, i % 4); end
            checks++; if (res_data !== sbq[0][31:0]) begin failures++; $display("FAIL rr_data[%0d] got=%08h want=%08h", i, res_data, sbq[0][31:0]); end
            checks++; if (op_count !== exp_count()) begin failures++; $display("FAIL rr_count[%0d] got=%0d want=%0d", i, op_count, exp_count()); end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        logic [3:0]  g;
        logic [31:0] held;
        apply_reset();
        req_data[31:0] = 32'h1234_5678;
        req_amt[4:0] = 5'd8;
        req_dir[0] = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        tick(g);
        req_valid = 4'b1010;
        held = res_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%04b want=0000", i, req_ready); end
            tick(g);
            checks++; if (res_valid !== 1'b1 || res_data !== held) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%08h want=1/%08h", i, res_valid, res_data, held); end
        end
        checks++; if (held !== 32'h3456_7812) begin failures++; $display("FAIL bp_first got=%08h want=34567812", held); end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%04b want=0010", req_ready); end
        tick(g);
        req_valid = 4'h0;
        checks++; if (res_id !== 2'd1 || res_data !== sbq[0][31:0]) begin failures++; $display("FAIL bp_next got=%0d/%08h want=1/%08h", res_id, res_data, sbq[0][31:0]); end
    endtask

    task automatic test_reset_midop();
        logic [3:0] g;
        apply_reset();
        req_data[95:64] = 32'hDEAD_BEEF;
        req_valid = 4'b0100;
        res_ready = 1'b0;
        tick(g);
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin failures++; $display("FAIL mid_setup got=%0b/%0d want=1/2", res_valid, res_id); end
        req_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        mvalid = 1'b0;
        mptr = 2'd0;
        hs = 0;
        sbq.delete();
        #1;
        checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_id !== 2'd0) begin failures++; $display("FAIL mid_async got=%0b/%08h/%0d want=0/00000000/0", res_valid, res_data, res_id); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_reset got=%04b want=0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%04b want=0001", req_ready); end
        tick(g);
        req_valid = 4'h0;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin failures++; $display("FAIL mid_first_result got=%0b/%0d want=1/0", res_valid, res_id); end
    endtask

    task automatic test_random();
        logic [3:0] g;
        apply_reset();
        req_valid = 4'h0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_data[32*i +: 32] = $urandom;
                    req_amt[5*i +: 5] = 5'($urandom_range(0, 31));
                    req_dir[i] = 1'($urandom_range(0, 1));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (req_ready !== exp_grant()) begin failures++; $display("FAIL rand_ready[%0d] got=%04b want=%04b", c, req_ready, exp_grant()); end
            tick(g);
            req_valid = req_valid & ~g;
            checks++; if (res_valid !== mvalid) begin failures++; $display("FAIL rand_valid[%0d] got=%0b want=%0b", c, res_valid, mvalid); end
            if (mvalid) begin
                checks++; if ({res_id, res_data} !== sbq[0]) begin failures++; $display("FAIL rand_result[%0d] got=%0d/%08h want=%0d/%08h", c, res_id, res_data, sbq[0][33:32], sbq[0][31:0]); end
            end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_count();
        logic [3:0] g;
        apply_reset();
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick(g);
            checks++; if (op_count !== exp_count()) begin failures++; $display("FAIL count[%0d] got=%0d want=%0d", c, op_count, exp_count()); end
        end
        req_valid = 4'h0;
`ifdef ROT_ARB_CNT_EN
        checks++; if (op_count !== 4'd15) begin failures++; $display("FAIL count_saturate got=%0d want=15", op_count); end
`else
        checks++; if (op_count !== '0) begin failures++; $display("FAIL count_absent got=%0d want=0", op_count); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rotate_single();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        test_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
